// File: rtl/trig_sequencer.sv
// Frame trigger sequencer: issues a TRIG_LEN-cycle active-low trigger, then waits for enabled syncs or timeout.
// Latency: request at edge n drives trig low for n+1..n+TRIG_LEN; requests arriving while busy are dropped and flagged.
module trig_sequencer #(
    parameter int TRIG_LEN  = 4,
    parameter int PER_BITS  = 32,
    parameter int TOUT_BITS = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [PER_BITS-1:0]  period,
    input  logic [TOUT_BITS-1:0] tout,
    input  logic [2:0]           enchn,
    input  logic                 ext_trig,
    input  logic [2:0]           sync,
    output logic                 trig,
    output logic                 busy,
    output logic                 frame_done,
    output logic [2:0]           missed,
    output logic [15:0]          frame_cnt,
    output logic                 overrun
);

    localparam int LEN_BITS = (TRIG_LEN > 1) ? $clog2(TRIG_LEN) : 1;
    localparam logic [LEN_BITS-1:0] LEN_LAST = LEN_BITS'(TRIG_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TRIG = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 trig_q, trig_d;
    logic [LEN_BITS-1:0]  len_cnt_q, len_cnt_d;
    logic [TOUT_BITS-1:0] tout_cnt_q, tout_cnt_d;
    logic [PER_BITS-1:0]  per_cnt_q, per_cnt_d;
    logic [2:0]           pending_q, pending_d;
    logic [2:0]           missed_q, missed_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;
    logic                 frame_done_q, frame_done_d;
    logic                 overrun_q, overrun_d;

    logic                 timer_hit;
    logic                 req;
    logic [2:0]           pending_clr;
    logic                 tout_hit;

    always_comb begin
        state_d      = state_q;
        trig_d       = trig_q;
        len_cnt_d    = len_cnt_q;
        tout_cnt_d   = tout_cnt_q;
        per_cnt_d    = per_cnt_q;
        pending_d    = pending_q;
        missed_d     = missed_q;
        frame_cnt_d  = frame_cnt_q;
        frame_done_d = 1'b0;
        overrun_d    = 1'b0;
        timer_hit    = 1'b0;

        // >= rather than == so a period shrunk below the running count still wraps promptly
        if (mode && (period != '0)) begin
            if (per_cnt_q >= period - PER_BITS'(1)) begin
                per_cnt_d = '0;
                timer_hit = 1'b1;
            end else begin
                per_cnt_d = per_cnt_q + PER_BITS'(1);
            end
        end else begin
            per_cnt_d = '0;
        end

        req         = mode & (timer_hit | ext_trig);
        pending_clr = pending_q & ~sync;
        tout_hit    = (tout != '0) && (tout_cnt_q == tout - TOUT_BITS'(1));

        if (req && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                trig_d = 1'b1;
                if (req) begin
                    state_d   = ST_TRIG;
                    trig_d    = 1'b0;
                    pending_d = enchn;
                    len_cnt_d = '0;
                end
            end
            ST_TRIG: begin
                pending_d = pending_clr;
                if (len_cnt_q == LEN_LAST) begin
                    state_d    = ST_WAIT;
                    trig_d     = 1'b1;
                    tout_cnt_d = '0;
                end else begin
                    len_cnt_d = len_cnt_q + LEN_BITS'(1);
                end
            end
            ST_WAIT: begin
                // a sync landing on the timeout cycle clears its bit before missed is captured
                pending_d  = pending_clr;
                tout_cnt_d = tout_cnt_q + TOUT_BITS'(1);
                if ((pending_clr == 3'b000) || tout_hit) begin
                    state_d      = ST_DONE;
                    frame_done_d = 1'b1;
                    missed_d     = pending_clr;
                    frame_cnt_d  = frame_cnt_q + 16'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // free-running mode overrides everything: trigger held low, any frame in flight is dropped
        if (!mode) begin
            state_d      = ST_IDLE;
            trig_d       = 1'b0;
            frame_done_d = 1'b0;
            missed_d     = missed_q;
            frame_cnt_d  = frame_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            trig_q       <= 1'b1;
            len_cnt_q    <= '0;
            tout_cnt_q   <= '0;
            per_cnt_q    <= '0;
            pending_q    <= 3'b000;
            missed_q     <= 3'b000;
            frame_cnt_q  <= 16'd0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            trig_q       <= trig_d;
            len_cnt_q    <= len_cnt_d;
            tout_cnt_q   <= tout_cnt_d;
            per_cnt_q    <= per_cnt_d;
            pending_q    <= pending_d;
            missed_q     <= missed_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign trig       = trig_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = frame_done_q;
    assign missed     = missed_q;
    assign frame_cnt  = frame_cnt_q;
    assign overrun    = overrun_q;

endmodule
